// File: rtl/rs_alu_station_pkg.sv
// Shared definitions for the integer ALU reservation station: tag/opcode constants and entry field widths.
// Age-based selection is enabled by defining RS_AGE_SELECT_EN.
`ifndef RS_ALU_STATION_DEFS
`define RS_ALU_STATION_DEFS
`define RS_VAL_W 32
`define RS_TAG_W 4
`define RS_OP_W  5
`endif

package rs_alu_station_pkg;
  localparam int RS_TAG_W = `RS_TAG_W;
  localparam int RS_OP_W  = `RS_OP_W;
  localparam int RS_VAL_W = `RS_VAL_W;
  // Tag value meaning "operand already holds its value".
  localparam int TAG_NONE = 0;

  typedef enum logic [`RS_OP_W-1:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_AND  = 5'd2,
    OP_OR   = 5'd3,
    OP_XOR  = 5'd4,
    OP_SLL  = 5'd5,
    OP_SRL  = 5'd6,
    OP_SRA  = 5'd7,
    OP_SLT  = 5'd8,
    OP_SLTU = 5'd9
  } alu_op_e;
endpackage

// File: rtl/rs_select.sv
// Combinational picker over the ready vector: lowest index by default, oldest entry
// (ties to lowest index) when RS_AGE_SELECT_EN is defined.
module rs_select #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [DEPTH-1:0]            ready,
`ifdef RS_AGE_SELECT_EN
  input  logic [DEPTH-1:0][IDX_W-1:0] age,
`endif
  output logic                        found,
  output logic [IDX_W-1:0]            index
);

`ifdef RS_AGE_SELECT_EN
  logic [IDX_W-1:0] best_age;

  // Strict '>' keeps the earlier (lower) index on equal ages.
  always_comb begin
    found    = 1'b0;
    index    = '0;
    best_age = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!found || age[i] > best_age)) begin
        found    = 1'b1;
        index    = IDX_W'(i);
        best_age = age[i];
      end
    end
  end
`else
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/rs_alu_station.sv
// Reservation station for integer ALU ops: captures dispatched ops, wakes operands from the
// CDB and issues one ready op per cycle through a registered ALU port. Option: RS_AGE_SELECT_EN.
module rs_alu_station
  import rs_alu_station_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = RS_TAG_W,
  parameter int OP_W  = RS_OP_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             disp_valid,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [31:0]      disp_vj,
  input  logic [31:0]      disp_vk,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [TAG_W-1:0] disp_qk,
  input  logic [TAG_W-1:0] disp_dest,
  output logic             full,
  input  logic             cdb_active,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_val,
  output logic             alu_valid,
  input  logic             alu_ready,
  output logic [OP_W-1:0]  alu_op,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [TAG_W-1:0] alu_dest
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] busy_reg;
  logic [OP_W-1:0]  op_reg   [DEPTH];
  logic [31:0]      vj_reg   [DEPTH];
  logic [31:0]      vk_reg   [DEPTH];
  logic [TAG_W-1:0] qj_reg   [DEPTH];
  logic [TAG_W-1:0] qk_reg   [DEPTH];
  logic [TAG_W-1:0] dest_reg [DEPTH];
`ifdef RS_AGE_SELECT_EN
  logic [IDX_W-1:0] age_reg  [DEPTH];
  logic [DEPTH-1:0][IDX_W-1:0] age_vec;
`endif

  logic             alu_valid_reg;
  logic [OP_W-1:0]  alu_op_reg;
  logic [31:0]      alu_a_reg;
  logic [31:0]      alu_b_reg;
  logic [TAG_W-1:0] alu_dest_reg;

  logic [DEPTH-1:0] ready_vec;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] free_idx;
  logic             cdb_hit;
  logic             bypass_j;
  logic             bypass_k;
  logic             disp_en;
  logic             issue;

  assign full     = &busy_reg;
  assign cdb_hit  = rdy_in && cdb_active && (cdb_tag != TAG_W'(TAG_NONE));
  assign bypass_j = cdb_hit && (disp_qj == cdb_tag);
  assign bypass_k = cdb_hit && (disp_qk == cdb_tag);
  assign disp_en  = rdy_in && !flush_in && disp_valid && !full;
  // The output register can take a new op when empty or when its current op is accepted.
  assign issue    = rdy_in && !flush_in && sel_found && (!alu_valid_reg || alu_ready);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign ready_vec[gi] = busy_reg[gi] && (qj_reg[gi] == TAG_W'(TAG_NONE))
                             && (qk_reg[gi] == TAG_W'(TAG_NONE));
`ifdef RS_AGE_SELECT_EN
      assign age_vec[gi] = age_reg[gi];
`endif
    end
  endgenerate

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_reg[i]) free_idx = IDX_W'(i);
    end
  end

  rs_select #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_select (
    .ready (ready_vec),
`ifdef RS_AGE_SELECT_EN
    .age   (age_vec),
`endif
    .found (sel_found),
    .index (sel_idx)
  );

  // Dispatch only targets a slot that was free before this edge, so it never collides with issue.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_reg[i]   <= '0;
        vj_reg[i]   <= '0;
        vk_reg[i]   <= '0;
        qj_reg[i]   <= '0;
        qk_reg[i]   <= '0;
        dest_reg[i] <= '0;
`ifdef RS_AGE_SELECT_EN
        age_reg[i]  <= '0;
`endif
      end
    end else if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_in) begin
          busy_reg[i] <= 1'b0;
        end else if (disp_en && free_idx == IDX_W'(i)) begin
          busy_reg[i] <= 1'b1;
          op_reg[i]   <= disp_op;
          vj_reg[i]   <= bypass_j ? cdb_val : disp_vj;
          vk_reg[i]   <= bypass_k ? cdb_val : disp_vk;
          qj_reg[i]   <= bypass_j ? TAG_W'(TAG_NONE) : disp_qj;
          qk_reg[i]   <= bypass_k ? TAG_W'(TAG_NONE) : disp_qk;
          dest_reg[i] <= disp_dest;
`ifdef RS_AGE_SELECT_EN
          age_reg[i]  <= '0;
`endif
        end else begin
          if (issue && sel_idx == IDX_W'(i)) busy_reg[i] <= 1'b0;
          if (busy_reg[i] && cdb_hit && qj_reg[i] == cdb_tag) begin
            vj_reg[i] <= cdb_val;
            qj_reg[i] <= TAG_W'(TAG_NONE);
          end
          if (busy_reg[i] && cdb_hit && qk_reg[i] == cdb_tag) begin
            vk_reg[i] <= cdb_val;
            qk_reg[i] <= TAG_W'(TAG_NONE);
          end
`ifdef RS_AGE_SELECT_EN
          if (disp_en && busy_reg[i] && age_reg[i] != '1) age_reg[i] <= age_reg[i] + 1'b1;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      alu_valid_reg <= 1'b0;
      alu_op_reg    <= '0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_dest_reg  <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        alu_valid_reg <= 1'b0;
      end else if (issue) begin
        alu_valid_reg <= 1'b1;
        alu_op_reg    <= op_reg[sel_idx];
        alu_a_reg     <= vj_reg[sel_idx];
        alu_b_reg     <= vk_reg[sel_idx];
        alu_dest_reg  <= dest_reg[sel_idx];
      end else if (alu_ready) begin
        alu_valid_reg <= 1'b0;
      end
    end
  end

  assign alu_valid = alu_valid_reg;
  assign alu_op    = alu_op_reg;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_dest  = alu_dest_reg;

endmodule

// File: tb/tb_rs_alu_station.sv
// Directed testbench for rs_alu_station (default build, lowest-index select).
module tb_rs_alu_station;
  import rs_alu_station_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        flush_in = 1'b0;
  logic        disp_valid = 1'b0;
  logic [4:0]  disp_op = '0;
  logic [31:0] disp_vj = '0;
  logic [31:0] disp_vk = '0;
  logic [3:0]  disp_qj = '0;
  logic [3:0]  disp_qk = '0;
  logic [3:0]  disp_dest = '0;
  logic        full;
  logic        cdb_active = 1'b0;
  logic [3:0]  cdb_tag = '0;
  logic [31:0] cdb_val = '0;
  logic        alu_valid;
  logic        alu_ready = 1'b1;
  logic [4:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_dest;

  int vectors = 0;
  int miscompares = 0;
  logic [73:0] want;
  wire  [73:0] out_bus = {alu_valid, alu_op, alu_a, alu_b, alu_dest};

  rs_alu_station #(.DEPTH(8), .TAG_W(4), .OP_W(5)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_vj(disp_vj), .disp_vk(disp_vk),
    .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_dest(disp_dest), .full(full),
    .cdb_active(cdb_active), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_dest(alu_dest)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_disp(input logic [4:0] op, input logic [31:0] vj, input logic [31:0] vk,
                          input logic [3:0] qj, input logic [3:0] qk, input logic [3:0] dest);
    disp_valid = 1'b1;
    disp_op = op; disp_vj = vj; disp_vk = vk;
    disp_qj = qj; disp_qk = qk; disp_dest = dest;
    $display("disp op=%0d vj=%h vk=%h qj=%0d qk=%0d dest=%0d", op, vj, vk, qj, qk, dest);
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if (out_bus !== 74'd0 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got out=%h full=%b want out=0 full=0", out_bus, full);
    end
    step();
    rst_in = 1'b1;
    step();
  endtask

  task automatic test_basic();
    set_disp(OP_ADD, 32'd5, 32'd7, 4'd0, 4'd0, 4'd3);
    step();
    disp_valid = 1'b0;
    vectors++;
    if (alu_valid !== 1'b0) begin
      miscompares++; $display("FAIL basic_latency: got alu_valid=%b want 0", alu_valid);
    end
    step();
    want = {1'b1, OP_ADD, 32'd5, 32'd7, 4'd3};
    vectors++;
    if (out_bus !== want) begin
      miscompares++; $display("FAIL basic_issue: got %h want %h", out_bus, want);
    end
    step();
    vectors++;
    if ({full, alu_valid} !== 2'b00) begin
      miscompares++; $display("FAIL basic_drain: got full,valid=%b want 00", {full, alu_valid});
    end
  endtask

  task automatic test_wakeup();
    set_disp(OP_SUB, 32'hdead, 32'd1, 4'd2, 4'd0, 4'd6);
    step();
    disp_valid = 1'b0;
    cdb_active = 1'b1; cdb_tag = 4'd3; cdb_val = 32'hbad;
    step();
    cdb_tag = 4'd2; cdb_val = 32'h10;
    step();
    cdb_active = 1'b0;
    vectors++;
    if (alu_valid !== 1'b0) begin
      miscompares++; $display("FAIL wake_not_early: got alu_valid=%b want 0", alu_valid);
    end
    step();
    want = {1'b1, OP_SUB, 32'h10, 32'd1, 4'd6};
    vectors++;
    if (out_bus !== want) begin
      miscompares++; $display("FAIL wake_issue: got %h want %h", out_bus, want);
    end
    step();
  endtask

  task automatic test_bypass();
    cdb_active = 1'b1; cdb_tag = 4'd4; cdb_val = 32'd9;
    set_disp(OP_AND, 32'h77, 32'hf, 4'd4, 4'd0, 4'd2);
    step();
    disp_valid = 1'b0; cdb_active = 1'b0;
    step();
    want = {1'b1, OP_AND, 32'd9, 32'hf, 4'd2};
    vectors++;
    if (out_bus !== want) begin
      miscompares++; $display("FAIL bypass_j: got %h want %h", out_bus, want);
    end
    cdb_active = 1'b1; cdb_tag = 4'd4; cdb_val = 32'h20;
    set_disp(OP_OR, 32'd3, 32'h88, 4'd0, 4'd4, 4'd5);
    step();
    disp_valid = 1'b0; cdb_active = 1'b0;
    step();
    want = {1'b1, OP_OR, 32'd3, 32'h20, 4'd5};
    vectors++;
    if (out_bus !== want) begin
      miscompares++; $display("FAIL bypass_k: got %h want %h", out_bus, want);
    end
    step();
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      set_disp(OP_XOR, 32'd0, 32'(i), 4'd5, 4'd0, 4'(i + 1));
      step();
      if (i == 6) begin
        vectors++;
        if (full !== 1'b0) begin
          miscompares++; $display("FAIL full_at7: got full=%b want 0", full);
        end
      end
    end
    disp_valid = 1'b0;
    vectors++;
    if (full !== 1'b1) begin
      miscompares++; $display("FAIL full_at8: got full=%b want 1", full);
    end
    set_disp(OP_ADD, 32'haa, 32'hbb, 4'd0, 4'd0, 4'd15);
    step();
    disp_valid = 1'b0;
    step();
    vectors++;
    if ({full, alu_valid} !== 2'b10) begin
      miscompares++; $display("FAIL full_drop: got full,valid=%b want 10", {full, alu_valid});
    end
    cdb_active = 1'b1; cdb_tag = 4'd5; cdb_val = 32'h55;
    step();
    cdb_active = 1'b0;
    step();
    want = {1'b1, OP_XOR, 32'h55, 32'd0, 4'd1};
    vectors++;
    if (out_bus !== want || full !== 1'b0) begin
      miscompares++; $display("FAIL full_first: got %h full=%b want %h full=0", out_bus, full, want);
    end
    for (int k = 1; k < 8; k++) begin
      step();
      want = {1'b1, OP_XOR, 32'h55, 32'(k), 4'(k + 1)};
      vectors++;
      if (out_bus !== want) begin
        miscompares++; $display("FAIL full_order%0d: got %h want %h", k, out_bus, want);
      end
    end
    step();
    vectors++;
    if ({full, alu_valid} !== 2'b00) begin
      miscompares++; $display("FAIL full_drain: got full,valid=%b want 00", {full, alu_valid});
    end
  endtask

  task automatic test_stall();
    alu_ready = 1'b0;
    set_disp(OP_ADD, 32'h11, 32'd1, 4'd0, 4'd0, 4'd1);
    step();
    set_disp(OP_SUB, 32'h22, 32'd2, 4'd0, 4'd0, 4'd2);
    step();
    set_disp(OP_SLL, 32'h33, 32'd3, 4'd0, 4'd0, 4'd3);
    step();
    disp_valid = 1'b0;
    want = {1'b1, OP_ADD, 32'h11, 32'd1, 4'd1};
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (out_bus !== want) begin
        miscompares++; $display("FAIL stall_hold%0d: got %h want %h", c, out_bus, want);
      end
      step();
    end
    alu_ready = 1'b1;
    // Slot 0 was refilled by the third op, so it leaves before the op in slot 1.
    step();
    want = {1'b1, OP_SLL, 32'h33, 32'd3, 4'd3};
    vectors++;
    if (out_bus !== want) begin
      miscompares++; $display("FAIL stall_next: got %h want %h", out_bus, want);
    end
    step();
    want = {1'b1, OP_SUB, 32'h22, 32'd2, 4'd2};
    vectors++;
    if (out_bus !== want) begin
      miscompares++; $display("FAIL stall_last: got %h want %h", out_bus, want);
    end
    step();
  endtask

  task automatic test_freeze();
    set_disp(OP_SRL, 32'd1, 32'd0, 4'd0, 4'd9, 4'd4);
    step();
    disp_valid = 1'b0;
    rdy_in = 1'b0;
    cdb_active = 1'b1; cdb_tag = 4'd9; cdb_val = 32'h99;
    step();
    rdy_in = 1'b1; cdb_val = 32'h98;
    step();
    cdb_active = 1'b0;
    vectors++;
    if (alu_valid !== 1'b0) begin
      miscompares++; $display("FAIL freeze_idle: got alu_valid=%b want 0", alu_valid);
    end
    step();
    want = {1'b1, OP_SRL, 32'd1, 32'h98, 4'd4};
    vectors++;
    if (out_bus !== want) begin
      miscompares++; $display("FAIL freeze_wake: got %h want %h", out_bus, want);
    end
    rdy_in = 1'b0;
    step();
    vectors++;
    if (out_bus !== want) begin
      miscompares++; $display("FAIL freeze_hold: got %h want %h", out_bus, want);
    end
    rdy_in = 1'b1;
    step();
  endtask

  task automatic test_flush();
    alu_ready = 1'b0;
    set_disp(OP_ADD, 32'd0, 32'd1, 4'd7, 4'd0, 4'd1);
    step();
    set_disp(OP_ADD, 32'd0, 32'd2, 4'd7, 4'd0, 4'd2);
    step();
    set_disp(OP_AND, 32'h33, 32'd3, 4'd0, 4'd0, 4'd3);
    step();
    disp_valid = 1'b0;
    step();
    flush_in = 1'b1;
    set_disp(OP_OR, 32'h44, 32'd4, 4'd0, 4'd0, 4'd14);
    step();
    flush_in = 1'b0; disp_valid = 1'b0;
    vectors++;
    if ({full, alu_valid} !== 2'b00) begin
      miscompares++; $display("FAIL flush_clear: got full,valid=%b want 00", {full, alu_valid});
    end
    alu_ready = 1'b1;
    cdb_active = 1'b1; cdb_tag = 4'd7; cdb_val = 32'h70;
    for (int c = 0; c < 2; c++) begin
      step();
      cdb_active = 1'b0;
      vectors++;
      if (alu_valid !== 1'b0) begin
        miscompares++; $display("FAIL flush_empty%0d: got alu_valid=%b want 0", c, alu_valid);
      end
    end
    set_disp(OP_ADD, 32'h50, 32'd5, 4'd0, 4'd0, 4'd5);
    step();
    disp_valid = 1'b0;
    step();
    want = {1'b1, OP_ADD, 32'h50, 32'd5, 4'd5};
    vectors++;
    if (out_bus !== want) begin
      miscompares++; $display("FAIL flush_after: got %h want %h", out_bus, want);
    end
    step();
  endtask

  task automatic test_reset_mid();
    alu_ready = 1'b0;
    set_disp(OP_SUB, 32'h66, 32'd6, 4'd0, 4'd0, 4'd6);
    step();
    set_disp(OP_SUB, 32'd0, 32'd0, 4'd8, 4'd0, 4'd7);
    step();
    disp_valid = 1'b0;
    #2;
    rst_in = 1'b0;
    #1;
    vectors++;
    if (out_bus !== 74'd0 || full !== 1'b0) begin
      miscompares++; $display("FAIL reset_async: got out=%h full=%b want out=0 full=0", out_bus, full);
    end
    step();
    rst_in = 1'b1; alu_ready = 1'b1;
    cdb_active = 1'b1; cdb_tag = 4'd8; cdb_val = 32'h1;
    step();
    cdb_active = 1'b0;
    step();
    vectors++;
    if (alu_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_wiped: got alu_valid=%b want 0", alu_valid);
    end
    set_disp(OP_XOR, 32'h5a, 32'ha5, 4'd0, 4'd0, 4'd9);
    step();
    disp_valid = 1'b0;
    step();
    want = {1'b1, OP_XOR, 32'h5a, 32'ha5, 4'd9};
    vectors++;
    if (out_bus !== want) begin
      miscompares++; $display("FAIL reset_after: got %h want %h", out_bus, want);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_full();
    test_stall();
    test_freeze();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
